multi_tap_correlator: RTL and testbench

Parametrised correlator bank for one tracking channel. It takes the I and Q carrier-mixer outputs and the code generator's half-chip-rate code stream. It builds NTAPS code replicas at a programmable half-chip spacing and integrates I/Q per tap with saturation. On each dump it hands the results to the processor interface through a valid/ack holding register with overrun detection. It generalises the fixed early/prompt/late six-accumulator arrangement to N taps and adds saturation and a dump handshake.

---
 rtl/multi_tap_correlator.sv | 152 +++++++++++++++
 tb/tb_multi_tap_correlator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tap_correlator.sv
// rtl/multi_tap_correlator.sv - N-tap I/Q code correlator with saturating integrators
// and a valid/ack dump holding register with overrun detection.
module multi_tap_correlator #(
  parameter int NTAPS   = 3,
  parameter int SPACING = 1,
  parameter int ACC_W   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     mix_i_sign,
  input  logic                     mix_q_sign,
  input  logic [2:0]               mix_i_mag,
  input  logic [2:0]               mix_q_mag,
  input  logic                     code_in,
  input  logic                     hc_enable,
  input  logic                     dump_enable,
  input  logic                     dump_ack,
  output logic [NTAPS*ACC_W-1:0]   i_acc,
  output logic [NTAPS*ACC_W-1:0]   q_acc,
  output logic                     dump_valid,
  output logic                     overrun,
  output logic [NTAPS-1:0]         sat
);

  localparam int L = (NTAPS - 1) * SPACING + 1;
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  logic [L-1:0]              sr;
  logic signed [ACC_W-1:0]   acc_i  [NTAPS];
  logic signed [ACC_W-1:0]   acc_q  [NTAPS];
  logic signed [ACC_W-1:0]   term_i [NTAPS];
  logic signed [ACC_W-1:0]   term_q [NTAPS];
  logic signed [ACC_W-1:0]   sum_i  [NTAPS];
  logic signed [ACC_W-1:0]   sum_q  [NTAPS];
  logic [NTAPS-1:0]          ovf;
  logic [NTAPS-1:0]          sat_run;
  state_t                    state, state_nx;

  function automatic logic signed [ACC_W-1:0] term_of(input logic sgn, input logic [2:0] mag,
                                                      input logic c);
    logic signed [ACC_W-1:0] m;
    m = $signed({{(ACC_W-3){1'b0}}, mag});
    return (sgn ^ c) ? -m : m;
  endfunction

  // Returns {overflow, clamped sum}; overflow shows up as disagreeing top two bits.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] t);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {t[ACC_W-1], t};
    if (s[ACC_W] != s[ACC_W-1])
      return {1'b1, (s[ACC_W] ? MINV : MAXV)};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  generate
    if (L == 1) begin : g_sr1
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          sr <= '0;
        else if (hc_enable) sr <= code_in;
      end
    end else begin : g_srn
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          sr <= '0;
        else if (hc_enable) sr <= {sr[L-2:0], code_in};
      end
    end
  endgenerate

  always_comb begin
    ovf = '0;
    for (int k = 0; k < NTAPS; k++) begin
      logic [ACC_W:0] ri, rq;
      term_i[k] = term_of(mix_i_sign, mix_i_mag, sr[k*SPACING]);
      term_q[k] = term_of(mix_q_sign, mix_q_mag, sr[k*SPACING]);
      ri        = sat_add(acc_i[k], term_i[k]);
      rq        = sat_add(acc_q[k], term_q[k]);
      sum_i[k]  = ri[ACC_W-1:0];
      sum_q[k]  = rq[ACC_W-1:0];
      ovf[k]    = ri[ACC_W] | rq[ACC_W];
    end
  end

  // A dump cycle's own sample opens the next interval rather than closing this one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NTAPS; k++) begin
        acc_i[k] <= '0;
        acc_q[k] <= '0;
      end
      sat_run <= '0;
    end else if (dump_enable) begin
      for (int k = 0; k < NTAPS; k++) begin
        acc_i[k] <= term_i[k];
        acc_q[k] <= term_q[k];
      end
      sat_run <= '0;
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        acc_i[k] <= sum_i[k];
        acc_q[k] <= sum_q[k];
      end
      sat_run <= sat_run | ovf;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_acc <= '0;
      q_acc <= '0;
      sat   <= '0;
    end else if (dump_enable) begin
      for (int k = 0; k < NTAPS; k++) begin
        i_acc[k*ACC_W +: ACC_W] <= acc_i[k];
        q_acc[k*ACC_W +: ACC_W] <= acc_q[k];
      end
      sat <= sat_run;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (dump_enable) state_nx = FULL;
      FULL:    if (dump_ack && !dump_enable) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    dump_valid = (state == FULL);
  end

  // Overrun is sticky until the processor acknowledges; a same-cycle ack excuses the dump.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      overrun <= 1'b0;
    else if (state == FULL && dump_enable && !dump_ack)
      overrun <= 1'b1;
    else if (state == FULL && dump_ack)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_multi_tap_correlator.sv
// tb/tb_multi_tap_correlator.sv - directed bench for multi_tap_correlator
// A: NTAPS=3 SPACING=1 ACC_W=16; B: NTAPS=3 SPACING=2 ACC_W=8, sharing stimulus.
module tb_multi_tap_correlator;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic mix_i_sign = 0, mix_q_sign = 0;
  logic [2:0] mix_i_mag = 0, mix_q_mag = 0;
  logic code_in = 0, hc_enable = 0, dump_enable = 0, dump_ack = 0;

  logic [47:0] i_a, q_a;
  logic        dv_a, ov_a;
  logic [2:0]  sat_a;
  logic [23:0] i_b, q_b;
  logic        dv_b, ov_b;
  logic [2:0]  sat_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_tap_correlator #(.NTAPS(3), .SPACING(1), .ACC_W(16)) dut_a (
    .clk(clk), .rstn(rstn),
    .mix_i_sign(mix_i_sign), .mix_q_sign(mix_q_sign),
    .mix_i_mag(mix_i_mag), .mix_q_mag(mix_q_mag),
    .code_in(code_in), .hc_enable(hc_enable),
    .dump_enable(dump_enable), .dump_ack(dump_ack),
    .i_acc(i_a), .q_acc(q_a), .dump_valid(dv_a), .overrun(ov_a), .sat(sat_a)
  );

  multi_tap_correlator #(.NTAPS(3), .SPACING(2), .ACC_W(8)) dut_b (
    .clk(clk), .rstn(rstn),
    .mix_i_sign(mix_i_sign), .mix_q_sign(mix_q_sign),
    .mix_i_mag(mix_i_mag), .mix_q_mag(mix_q_mag),
    .code_in(code_in), .hc_enable(hc_enable),
    .dump_enable(dump_enable), .dump_ack(dump_ack),
    .i_acc(i_b), .q_acc(q_b), .dump_valid(dv_b), .overrun(ov_b), .sat(sat_b)
  );

  typedef struct {
    logic       isg;
    logic [2:0] imag;
    logic       qsg;
    logic [2:0] qmag;
    logic       code;
    int         n;
    int         ei;
    int         eq;
  } vec_t;

  vec_t tbl[5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic c, input logic hc, input logic d, input logic a,
                     input logic isg, input logic [2:0] im, input logic qs, input logic [2:0] qm);
    code_in = c; hc_enable = hc; dump_enable = d; dump_ack = a;
    mix_i_sign = isg; mix_i_mag = im; mix_q_sign = qs; mix_q_mag = qm;
  endtask

  task automatic do_reset;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic longint ta(input logic [47:0] v, input int k);
    logic [15:0] s;
    s = v[k*16 +: 16];
    return longint'($signed(s));
  endfunction

  function automatic longint tb(input logic [23:0] v, input int k);
    logic [7:0] s;
    s = v[k*8 +: 8];
    return longint'($signed(s));
  endfunction

  task automatic chk_a(input string nm, input int ei0, input int ei1, input int ei2, input int eq);
    chk($sformatf("%s_a_i0", nm), ta(i_a, 0), ei0);
    chk($sformatf("%s_a_i1", nm), ta(i_a, 1), ei1);
    chk($sformatf("%s_a_i2", nm), ta(i_a, 2), ei2);
    for (int k = 0; k < 3; k++) chk($sformatf("%s_a_q%0d", nm, k), ta(q_a, k), eq);
  endtask

  initial begin
    tbl[0] = '{isg:0, imag:5, qsg:1, qmag:3, code:0, n:100, ei:500,  eq:-300};
    tbl[1] = '{isg:0, imag:5, qsg:1, qmag:3, code:1, n:100, ei:-500, eq:300};
    tbl[2] = '{isg:1, imag:7, qsg:0, qmag:7, code:0, n:50,  ei:-350, eq:350};
    tbl[3] = '{isg:1, imag:2, qsg:1, qmag:4, code:1, n:30,  ei:60,   eq:120};
    tbl[4] = '{isg:0, imag:0, qsg:0, qmag:1, code:0, n:1,   ei:0,    eq:1};

    do_reset();
    chk("rst_dv", dv_a, 0);
    chk("rst_ov", ov_a, 0);
    chk("rst_i", i_a, 0);
    chk("rst_sat", sat_a, 0);

    // constant integration across code polarities and mixer patterns
    for (int v = 0; v < 5; v++) begin
      do_reset();
      drv(tbl[v].code, 1, 0, 0, 0, 0, 0, 0);
      repeat (8) tick();
      drv(tbl[v].code, 0, 0, 0, tbl[v].isg, tbl[v].imag, tbl[v].qsg, tbl[v].qmag);
      repeat (tbl[v].n) tick();
      drv(tbl[v].code, 0, 1, 0, 0, 0, 0, 0);
      tick();
      chk_a($sformatf("vec%0d", v), tbl[v].ei, tbl[v].ei, tbl[v].ei, tbl[v].eq);
      chk($sformatf("vec%0d_dv", v), dv_a, 1);
      chk($sformatf("vec%0d_sat", v), sat_a, 0);
      drv(tbl[v].code, 0, 0, 1, 0, 0, 0, 0);
      tick();
      chk($sformatf("vec%0d_ackdv", v), dv_a, 0);
    end

    // tap spacing: one code chip walks down the delay line
    do_reset();
    drv(1, 1, 0, 0, 0, 1, 0, 0); tick();
    drv(0, 1, 0, 0, 0, 1, 0, 0); tick(); tick();
    drv(0, 1, 1, 0, 0, 1, 0, 0); tick();
    chk("sp1_b_i0", tb(i_b, 0), 1);
    chk("sp1_b_i1", tb(i_b, 1), 3);
    chk("sp1_b_i2", tb(i_b, 2), 3);
    chk_a("sp1", 1, 1, 3, 0);
    drv(0, 1, 0, 1, 0, 1, 0, 0); tick();
    drv(0, 1, 0, 0, 0, 1, 0, 0);
    repeat (7) tick();
    drv(0, 1, 1, 0, 0, 0, 0, 0); tick();
    chk("sp2_b_i0", tb(i_b, 0), 9);
    chk("sp2_b_i1", tb(i_b, 1), 7);
    chk("sp2_b_i2", tb(i_b, 2), 7);
    chk_a("sp2", 9, 9, 7, 0);
    chk("sp2_b_ov", ov_b, 0);

    // saturation on the 8-bit instance
    do_reset();
    drv(0, 0, 0, 0, 0, 7, 1, 7);
    repeat (40) tick();
    drv(0, 0, 1, 0, 0, 7, 1, 7); tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sat_b_i%0d", k), tb(i_b, k), 127);
      chk($sformatf("sat_b_q%0d", k), tb(q_b, k), -128);
    end
    chk("sat_b_flags", sat_b, 7);
    chk_a("sat", 280, 280, 280, -280);
    chk("sat_a_flags", sat_a, 0);
    drv(0, 0, 0, 0, 0, 7, 1, 7); tick();
    drv(0, 0, 1, 0, 0, 0, 0, 0); tick();
    chk("sat2_b_i0", tb(i_b, 0), 14);
    chk("sat2_b_q2", tb(q_b, 2), -14);
    chk("sat2_b_flags", sat_b, 0);
    chk("sat2_b_ov", ov_b, 1);

    // handshake and overrun
    do_reset();
    drv(0, 0, 0, 0, 0, 1, 0, 0); tick(); tick();
    drv(0, 0, 1, 0, 0, 1, 0, 0); tick();
    chk("hs1_i", ta(i_a, 1), 2);
    chk("hs1_dv", dv_a, 1);
    chk("hs1_ov", ov_a, 0);
    drv(0, 0, 0, 0, 0, 1, 0, 0); tick(); tick();
    drv(0, 0, 1, 0, 0, 1, 0, 0); tick();
    chk("hs2_i", ta(i_a, 1), 3);
    chk("hs2_dv", dv_a, 1);
    chk("hs2_ov", ov_a, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("hs2_ov_sticky", ov_a, 1);
    drv(0, 0, 1, 1, 0, 1, 0, 0); tick();
    chk("hs3_i", ta(i_a, 1), 1);
    chk("hs3_dv", dv_a, 1);
    chk("hs3_ov", ov_a, 0);
    drv(0, 0, 0, 1, 0, 0, 0, 0); tick();
    chk("hs4_dv", dv_a, 0);
    chk("hs4_ov", ov_a, 0);
    tick();
    chk("hs5_empty_ack_dv", dv_a, 0);

    // back-to-back dumps
    do_reset();
    drv(0, 0, 0, 0, 0, 3, 0, 0); tick(); tick();
    drv(0, 0, 1, 0, 0, 3, 0, 0); tick();
    chk("b2b1_i", ta(i_a, 0), 6);
    tick();
    chk("b2b2_i", ta(i_a, 0), 3);
    chk("b2b2_i2", ta(i_a, 2), 3);
    chk("b2b2_ov", ov_a, 1);

    // asynchronous reset mid-interval with held data
    drv(0, 0, 0, 0, 0, 5, 0, 0); tick(); tick();
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_dv", dv_a, 0);
    chk("arst_ov", ov_a, 0);
    chk("arst_i", i_a, 0);
    chk("arst_q", q_a, 0);
    chk("arst_sat_b", sat_b, 0);
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    drv(0, 0, 1, 0, 0, 0, 0, 0); tick();
    chk("arst_post_i", ta(i_a, 1), 20);
    chk("arst_post_dv", dv_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
